// File: rtl/alu_mem_datapath.sv
// alu_mem_datapath: execute-and-memory slice of a single-cycle LEGv8 CPU.
// Holds a 64-bit combinational ALU, a read-only 32-bit instruction ROM and a
// byte-addressed 64-bit data memory whose address is the ALU result.
// Optional build macro: ALU_SHIFT_EN adds ALU codes 0011 (LSL) and 0100 (LSR).
module alu_mem_datapath #(
    parameter int IMEM_WORDS = 64,
    parameter int DMEM_WORDS = 32
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic [63:0] InstAddress,
    output logic [31:0] Instruction,
    input  logic [63:0] BusA,
    input  logic [63:0] BusB,
    input  logic [3:0]  ALUCtrl,
    output logic [63:0] BusW,
    output logic        Zero,
    input  logic [63:0] WriteData,
    input  logic        MemoryRead,
    input  logic        MemoryWrite,
    output logic [63:0] ReadData
);

    localparam int IMEM_AW = $clog2(IMEM_WORDS);
    localparam int DMEM_AW = $clog2(DMEM_WORDS);

    // ALU operation codes
    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_LSL  = 4'b0011;
    localparam logic [3:0] OP_LSR  = 4'b0100;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_PASS = 4'b0111;

    // ALU evaluation; unknown codes produce zero so Zero reads as 1.
    function automatic logic [63:0] alu_eval(
        input logic [3:0]  ctrl,
        input logic [63:0] a,
        input logic [63:0] b
    );
        logic [63:0] r;
        case (ctrl)
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_ADD:  r = a + b;
            OP_SUB:  r = a - b;
            OP_PASS: r = b;
`ifdef ALU_SHIFT_EN
            OP_LSL:  r = a << b[5:0];
            OP_LSR:  r = a >> b[5:0];
`endif
            default: r = 64'h0;
        endcase
        return r;
    endfunction

    logic [63:0]        alu_result_s;
    logic [IMEM_AW-1:0] imem_idx_s;
    logic               imem_in_range_s;
    logic [31:0]        instruction_s;
    logic [DMEM_AW-1:0] dmem_idx_s;
    logic               dmem_in_range_s;
    logic [63:0]        read_data_s;
    logic [63:0]        mem_r [DMEM_WORDS];
    logic               unused_s;

    // Byte-offset bits are intentionally ignored (aligned accesses only).
    assign unused_s = ^{InstAddress[1:0], alu_result_s[2:0], OP_LSL, OP_LSR};

    // Combinational ALU and zero detect.
    always_comb begin
        alu_result_s = 64'h0;
        alu_result_s = alu_eval(ALUCtrl, BusA, BusB);
    end

    assign BusW = alu_result_s;
    assign Zero = ~|alu_result_s;

    // Instruction fetch index and range check; any bit above the index field kills the fetch.
    assign imem_idx_s      = InstAddress[IMEM_AW+1:2];
    assign imem_in_range_s = ~|InstAddress[63:IMEM_AW+2];

    // Fixed instruction ROM contents; unlisted words and out-of-range fetches read zero.
    always_comb begin
        instruction_s = 32'h0;
        if (imem_in_range_s) begin
            case (imem_idx_s)
                IMEM_AW'(0): instruction_s = 32'hF84003E9;
                IMEM_AW'(1): instruction_s = 32'hF84083EA;
                IMEM_AW'(2): instruction_s = 32'hF84103EB;
                IMEM_AW'(3): instruction_s = 32'h8B0A012C;
                default:     instruction_s = 32'h0;
            endcase
        end else begin
            instruction_s = 32'h0;
        end
    end

    assign Instruction = instruction_s;

    // Data memory word index and range check derived from the ALU result.
    assign dmem_idx_s      = alu_result_s[DMEM_AW+2:3];
    assign dmem_in_range_s = ~|alu_result_s[63:DMEM_AW+3];

    // Data memory storage: async clear on reset, in-range writes on the rising edge.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DMEM_WORDS; i++) begin
                mem_r[i] <= 64'h0;
            end
        end else if (MemoryWrite && dmem_in_range_s) begin
            mem_r[dmem_idx_s] <= WriteData;
        end
    end

    // Combinational load path gated by MemoryRead and the range check.
    always_comb begin
        read_data_s = 64'h0;
        if (MemoryRead && dmem_in_range_s) begin
            read_data_s = mem_r[dmem_idx_s];
        end else begin
            read_data_s = 64'h0;
        end
    end

    assign ReadData = read_data_s;

endmodule

// File: tb/tb_alu_mem_datapath.sv
// Directed self-checking bench for alu_mem_datapath (default parameters).
module tb_alu_mem_datapath;

    logic        CLK;
    logic        reset;
    logic [63:0] InstAddress;
    logic [31:0] Instruction;
    logic [63:0] BusA;
    logic [63:0] BusB;
    logic [3:0]  ALUCtrl;
    logic [63:0] BusW;
    logic        Zero;
    logic [63:0] WriteData;
    logic        MemoryRead;
    logic        MemoryWrite;
    logic [63:0] ReadData;

    int checks = 0;
    int errors = 0;

    alu_mem_datapath #(.IMEM_WORDS(64), .DMEM_WORDS(32)) dut (
        .CLK(CLK),
        .reset(reset),
        .InstAddress(InstAddress),
        .Instruction(Instruction),
        .BusA(BusA),
        .BusB(BusB),
        .ALUCtrl(ALUCtrl),
        .BusW(BusW),
        .Zero(Zero),
        .WriteData(WriteData),
        .MemoryRead(MemoryRead),
        .MemoryWrite(MemoryWrite),
        .ReadData(ReadData)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_alu(input logic [3:0] ctrl, input logic [63:0] a, input logic [63:0] b);
        ALUCtrl = ctrl;
        BusA    = a;
        BusB    = b;
        #1;
    endtask

    // Address the data memory through ADD (0 + addr).
    task automatic set_addr(input logic [63:0] addr);
        set_alu(4'b0010, 64'h0, addr);
    endtask

    task automatic do_write(input logic [63:0] addr, input logic [63:0] data);
        @(negedge CLK);
        set_addr(addr);
        WriteData   = data;
        MemoryWrite = 1'b1;
        @(posedge CLK);
        #1;
        MemoryWrite = 1'b0;
    endtask

    task automatic do_read(input string tag, input logic [63:0] addr, input logic [63:0] exp);
        MemoryRead = 1'b1;
        set_addr(addr);
        check(tag, ReadData, exp);
    endtask

    initial begin
        reset       = 1'b1;
        InstAddress = 64'h0;
        BusA        = 64'h0;
        BusB        = 64'h0;
        ALUCtrl     = 4'b0010;
        WriteData   = 64'h0;
        MemoryRead  = 1'b1;
        MemoryWrite = 1'b0;
        #2;
        check("reset_readdata", ReadData, 64'h0);
        #10;
        reset = 1'b0;
        MemoryRead = 1'b0;

        // ALU
        set_alu(4'b0000, 64'h5, 64'h3); check("alu_and", BusW, 64'h1); check("alu_and_z", {63'h0, Zero}, 64'h0);
        set_alu(4'b0001, 64'h5, 64'h3); check("alu_or", BusW, 64'h7);
        set_alu(4'b0010, 64'h5, 64'h3); check("alu_add", BusW, 64'h8);
        set_alu(4'b0110, 64'h5, 64'h3); check("alu_sub", BusW, 64'h2);
        set_alu(4'b0111, 64'h5, 64'h3); check("alu_pass", BusW, 64'h3); check("alu_pass_z", {63'h0, Zero}, 64'h0);
        set_alu(4'b0110, 64'h9, 64'h9); check("alu_sub_eq", BusW, 64'h0); check("alu_sub_eq_z", {63'h0, Zero}, 64'h1);
        set_alu(4'b0110, 64'h0, 64'h1); check("alu_sub_wrap", BusW, 64'hFFFF_FFFF_FFFF_FFFF);
        set_alu(4'b0010, 64'hFFFF_FFFF_FFFF_FFFF, 64'h2); check("alu_add_wrap", BusW, 64'h1);
        set_alu(4'b1111, 64'h5, 64'h3); check("alu_other", BusW, 64'h0); check("alu_other_z", {63'h0, Zero}, 64'h1);
`ifdef ALU_SHIFT_EN
        set_alu(4'b0011, 64'h1, 64'h4); check("alu_lsl", BusW, 64'h10);
        set_alu(4'b0100, 64'h8000_0000_0000_0000, 64'd63); check("alu_lsr", BusW, 64'h1);
`else
        set_alu(4'b0011, 64'h1, 64'h4); check("alu_lsl_off", BusW, 64'h0); check("alu_lsl_off_z", {63'h0, Zero}, 64'h1);
        set_alu(4'b0100, 64'h8000_0000_0000_0000, 64'd63); check("alu_lsr_off", BusW, 64'h0);
`endif

        // Instruction ROM
        InstAddress = 64'd0;  #1; check("imem_0", {32'h0, Instruction}, 64'hF84003E9);
        InstAddress = 64'd4;  #1; check("imem_4", {32'h0, Instruction}, 64'hF84083EA);
        InstAddress = 64'd8;  #1; check("imem_8", {32'h0, Instruction}, 64'hF84103EB);
        InstAddress = 64'd12; #1; check("imem_12", {32'h0, Instruction}, 64'h8B0A012C);
        InstAddress = 64'd16; #1; check("imem_16", {32'h0, Instruction}, 64'h0);
        InstAddress = 64'h1_0000_0000; #1; check("imem_high", {32'h0, Instruction}, 64'h0);
        InstAddress = 64'd256; #1; check("imem_alias", {32'h0, Instruction}, 64'h0);
        InstAddress = 64'd5;  #1; check("imem_5", {32'h0, Instruction}, 64'hF84083EA);

        // Store then load, with read-before-write visibility on the same word
        @(negedge CLK);
        MemoryRead  = 1'b1;
        set_addr(64'd8);
        WriteData   = 64'hDEADBEEF;
        MemoryWrite = 1'b1;
        #1;
        check("rw_before_edge", ReadData, 64'h0);
        @(posedge CLK);
        #1;
        MemoryWrite = 1'b0;
        check("rw_after_edge", ReadData, 64'hDEADBEEF);
        MemoryRead = 1'b0; #1;
        check("read_disabled", ReadData, 64'h0);
        do_read("read_byte_off", 64'd12, 64'hDEADBEEF);

        // Boundary: DMEM_WORDS*8 is out of range and must not alias word 0
        do_write(64'd0, 64'hA5A5);
        do_write(64'd256, 64'hFFFF_0000_FFFF_0000);
        do_read("oob_word0", 64'd0, 64'hA5A5);
        do_read("oob_word1", 64'd8, 64'hDEADBEEF);
        do_read("oob_read", 64'd256, 64'h0);
        do_write(64'd248, 64'h3131);
        do_read("last_word", 64'd248, 64'h3131);

        // Asynchronous reset clears memory immediately and blocks writes
        do_write(64'd16, 64'h1234);
        do_read("pre_reset", 64'd16, 64'h1234);
        @(negedge CLK);
        reset = 1'b1;
        #1;
        check("reset_immediate", ReadData, 64'h0);
        do_read("reset_word0", 64'd0, 64'h0);
        do_write(64'd16, 64'h5555);
        @(negedge CLK);
        reset = 1'b0;
        do_read("write_in_reset", 64'd16, 64'h0);
        do_write(64'd24, 64'h77);
        do_read("post_reset_write", 64'd24, 64'h77);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_mem_datapath.md
Name: alu_mem_datapath

Overview:
Execute-and-memory slice of the single-cycle LEGv8 CPU: a 64-bit ALU, a byte-addressed 64-bit data memory, and a read-only 32-bit instruction memory in one block. Fetch uses InstAddress. The ALU result drives the data-memory address internally. Register file, control, sign extension and next-PC logic sit outside and connect to these ports.

Parameters:
IMEM_WORDS, 64, number of 32-bit instruction words (power of two, ≤1024)
DMEM_WORDS, 32, number of 64-bit data words (power of two, ≤1024)

Ports:
CLK  input  1  system clock; data-memory writes on rising edge
reset  input  1  asynchronous, active-high; clears data memory
InstAddress  input  64  byte address of instruction fetch
Instruction  output  32  fetched instruction word
BusA  input  64  ALU operand A
BusB  input  64  ALU operand B (already ALUSrc-muxed)
ALUCtrl  input  4  ALU operation select
BusW  output  64  ALU result; also the data-memory byte address
Zero  output  1  1 when BusW == 0
WriteData  input  64  store data
MemoryRead  input  1  enables ReadData
MemoryWrite  input  1  store enable
ReadData  output  64  load data

Behaviour:
- One clock (CLK). Reset is asynchronous and active-high; no other state is clocked.
- ALU (combinational, zero latency), 64-bit wrap-around arithmetic, no flags other than Zero:
  - 0000 AND; 0001 OR; 0010 ADD (A+B); 0110 SUB (A-B); 0111 PassB (B).
  - Any other code: BusW = 0, so Zero = 1.
- Zero = ~|BusW for every code.
- Instruction memory: combinational ROM.
  - idx = InstAddress[2+log2(IMEM_WORDS)-1:2]. InstAddress[1:0] is ignored.
  - If any InstAddress bit above the index field is 1, Instruction = 32'h0.
  - Fixed contents: word0 = 32'hF84003E9, word1 = 32'hF84083EA, word2 = 32'hF84103EB, word3 = 32'h8B0A012C. All other words = 0.
  - Not affected by reset.
- Data memory: DMEM_WORDS x 64 bits.
  - didx = BusW[3+log2(DMEM_WORDS)-1:3]. BusW[2:0] is ignored (aligned access only).
  - Address is in range when all BusW bits above the index field are 0.
  - Read is combinational: ReadData = mem[didx] when MemoryRead=1 and the address is in range; otherwise 64'h0.
  - Write on the rising edge of CLK when MemoryWrite=1, reset=0 and the address is in range: mem[didx] <= WriteData.
  - Out-of-range writes are dropped.
- Simultaneous read and write to the same word: before the edge ReadData shows the old value; after the edge it shows the new value.
- reset=1: all data words clear to 0 immediately, regardless of CLK. Writes are blocked while reset is high. An asserted reset wins over a coincident write edge.
- Reset values:
  - ReadData = 0.
  - BusW, Zero and Instruction remain combinational functions of their inputs.
- Releasing reset mid-cycle: the first write takes effect on the next rising edge.

Optional Feature:
ALU_SHIFT_EN: when defined, adds two ALU codes:
- 0011 LSL: BusW = BusA << BusB[5:0]
- 0100 LSR: BusW = BusA >> BusB[5:0] (logical)
When undefined, 0011 and 0100 fall into "other" (BusW=0, Zero=1).

Test Plan:
- ALU: A=64'h5, B=64'h3 through codes 0000/0001/0010/0110/0111 -> BusW = 1/7/8/2/3, Zero=0. A=B=64'h9 with SUB -> BusW=0, Zero=1. A=0, B=1 with SUB -> BusW=64'hFFFF_FFFF_FFFF_FFFF.
- IMEM: InstAddress 0/4/8/12 -> F84003E9/F84083EA/F84103EB/8B0A012C. Address 16 -> 0. Address 64'h1_0000_0000 -> 0. Address 5 -> F84083EA.
- DMEM store/load:
  - ADD A=0, B=8, WriteData=64'hDEADBEEF, MemoryWrite=1, one rising edge.
  - Then MemoryWrite=0, MemoryRead=1 -> ReadData=64'hDEADBEEF. Same with MemoryRead=0 -> ReadData=0.
- DMEM boundary: writing to byte address DMEM_WORDS*8 changes no word. Reading word 0 after that still returns the prior value.
- Reset: write 64'h1234 to address 16, then pulse reset between clock edges -> ReadData at address 16 = 0 immediately. A write asserted with reset high is ignored.
- With ALU_SHIFT_EN: A=1, B=4, code 0011 -> 64'h10. A=64'h8000_0000_0000_0000, B=63, code 0100 -> 1. Without the macro, code 0011 -> BusW=0, Zero=1.
